stopwatch_cpu_oci_dct_ctrl: RTL and testbench
=============================================

STOPWATCH_CPU_OCI_DCT_CTRL -- requirements
Module: stopwatch_CPU_oci_dct_ctrl

Interface
REQ-001 SHALL have parameter IDLE_FLUSH, default 255, idle cycles with a non-empty buffer before auto-flush (range 0..1023; 0 disables auto-flush).
REQ-002 SHALL have ports: clk  in  1  sole clock, all logic on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 trc_on  in  1  capture enable; fragments ignored while low.
REQ-005 frag_valid  in  1  trace fragment present this cycle.
REQ-006 frag  in  2  trace fragment.
REQ-007 flush  in  1  single-cycle request to emit a partial buffer.
REQ-008 ovf_clr  in  1  clears the sticky overflow flag.
REQ-009 dct_buffer  out  30  fill buffer; newest fragment in bits [1:0].
REQ-010 dct_count  out  4  fragments held in dct_buffer, 0..15.
REQ-011 word_valid  out  1  output word valid.
REQ-012 word_ready  in  1  consumer accepts the word when word_valid && word_ready.
REQ-013 word_data  out  30  packed word; word_cnt  out  4  fragment count of word_data.
REQ-014 overflow  out  1  sticky fragment-drop flag; word_ts  out  16  timestamp (see Configuration).

Function
REQ-015 SHALL implement states IDLE (dct_count=0), FILL (1..14), FULL (15), encoded from dct_count.
REQ-016 Accepted fragment (trc_on && frag_valid, state not FULL): dct_buffer <= {dct_buffer[27:0], frag}, dct_count+1, visible next cycle.
REQ-017 Fragment arriving in FULL without a same-cycle transfer SHALL be dropped and set overflow next cycle.
REQ-018 Output register free = !word_valid || word_ready.
REQ-019 Transfer SHALL occur when output free and (FULL, or flush_pend with dct_count != 0): word_data <= dct_buffer, word_cnt <= dct_count, word_valid <= 1.
REQ-020 On transfer, dct_count <= 0 and dct_buffer <= 0, except a same-cycle accepted fragment SHALL be loaded as {28'b0, frag} with dct_count=1 (zero drop at boundary).
REQ-021 flush SHALL set flush_pend; flush_pend clears on transfer or when dct_count=0; flush in IDLE produces no word.
REQ-022 Idle counter: counts cycles without an accepted fragment while dct_count != 0; reaching IDLE_FLUSH SHALL set flush_pend and reset the counter; counter clears on any accepted fragment or transfer.
REQ-023 word_valid SHALL hold, with word_data/word_cnt stable, until accepted; accept without new transfer clears word_valid next cycle.
REQ-024 Accept and transfer in same cycle SHALL load the new word back-to-back (word_valid stays 1).
REQ-025 trc_on low SHALL not clear buffer, pending flush or output word; transfers continue.
REQ-026 overflow clears on ovf_clr; set-and-clear same cycle SHALL leave overflow set.

Reset
REQ-027 reset SHALL clear dct_buffer, dct_count, word_data, word_cnt, word_valid, overflow, flush_pend, idle counter, word_ts, timestamp counter to 0.
REQ-028 reset mid-operation SHALL discard buffered and pending words, no word emitted; reset overrides all inputs.

Configuration
REQ-029 Macro DCT_TIMESTAMP_EN defined: 16-bit free-running cycle counter (wraps 0xFFFF->0) sampled into word_ts on each transfer.
REQ-030 Macro undefined: no counter, word_ts tied to 0; all other behaviour identical.

Verification
REQ-031 Reset, 15 fragments frag=2'b01 consecutive, word_ready=1 -> next cycle word_valid=1, word_data=30'h15555555, word_cnt=15, dct_count=0.
REQ-032 3 fragments 11,10,01 then flush pulse -> word_data=30'h39, word_cnt=3; flush with dct_count=0 -> no word.
REQ-033 word_ready=0, 31 fragments -> first word held, buffer FULL, 31st fragment dropped, overflow=1; ovf_clr -> overflow=0.
REQ-034 IDLE_FLUSH=4, one fragment then idle -> word_valid 5 cycles after fragment, word_cnt=1.
REQ-035 16th fragment arrives in FULL-transfer cycle -> word_cnt=15, dct_count=1, no overflow.
REQ-036 reset while FILL (dct_count=7) and word_valid=1 -> all outputs 0 next cycle; with DCT_TIMESTAMP_EN, word_ts equals transfer-cycle count after reset.

Source files
------------

// File: rtl/stopwatch_cpu_oci_dct_ctrl.sv
// Trace fragment packer: 15 x 2-bit fragments into a 30-bit word with flush/idle-flush.
// Optional DCT_TIMESTAMP_EN adds a free-running cycle stamp captured per word.
module stopwatch_cpu_oci_dct_ctrl #(
   parameter int unsigned IDLE_FLUSH = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        trc_on,
   input  logic        frag_valid,
   input  logic [1:0]  frag,
   input  logic        flush,
   input  logic        ovf_clr,
   output logic [29:0] dct_buffer,
   output logic [3:0]  dct_count,
   output logic        word_valid,
   input  logic        word_ready,
   output logic [29:0] word_data,
   output logic [3:0]  word_cnt,
   output logic        overflow,
   output logic [15:0] word_ts
);

   typedef enum logic [1:0] {S_IDLE, S_FILL, S_FULL} state_t;

   localparam logic [10:0] IDLE_LIM = 11'(IDLE_FLUSH);

   state_t      state;
   logic        flush_pend;
   logic [9:0]  idle_cnt;

   logic        full;
   logic        empty;
   logic        xfer;
   logic        accept;
   logic        drop;
   logic        idle_hit;
   logic [10:0] idle_inc;
   logic [29:0] buf_n;
   logic [3:0]  cnt_n;
   logic        pend_n;
   logic [9:0]  idle_n;
   logic        ovf_n;

   always_comb begin
      state = S_FILL;
      if (dct_count == 4'd0) state = S_IDLE;
      else if (dct_count == 4'd15) state = S_FULL;
   end

   always_comb begin
      full     = (state == S_FULL);
      empty    = (state == S_IDLE);
      xfer     = (!word_valid || word_ready) && (full || (flush_pend && !empty));
      // A fragment arriving while FULL still lands if the buffer drains this cycle
      accept   = trc_on && frag_valid && (!full || xfer);
      drop     = trc_on && frag_valid && full && !xfer;
      idle_inc = {1'b0, idle_cnt} + 11'd1;
      idle_hit = (IDLE_LIM != 11'd0) && !empty && !accept && !xfer
                 && (idle_inc == IDLE_LIM);

      buf_n = dct_buffer;
      cnt_n = dct_count;
      if (xfer) begin
         buf_n = accept ? {28'b0, frag} : 30'b0;
         cnt_n = accept ? 4'd1 : 4'd0;
      end else if (accept) begin
         buf_n = {dct_buffer[27:0], frag};
         cnt_n = dct_count + 4'd1;
      end

      pend_n = flush_pend;
      if (xfer || empty) pend_n = 1'b0;
      if (flush || idle_hit) pend_n = 1'b1;

      idle_n = idle_cnt + 10'd1;
      if (empty || accept || xfer || idle_hit || IDLE_LIM == 11'd0)
         idle_n = 10'd0;

      ovf_n = overflow;
      if (ovf_clr) ovf_n = 1'b0;
      if (drop) ovf_n = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         dct_buffer <= '0;
         dct_count  <= '0;
         flush_pend <= 1'b0;
         idle_cnt   <= '0;
         overflow   <= 1'b0;
         word_valid <= 1'b0;
         word_data  <= '0;
         word_cnt   <= '0;
      end else begin
         dct_buffer <= buf_n;
         dct_count  <= cnt_n;
         flush_pend <= pend_n;
         idle_cnt   <= idle_n;
         overflow   <= ovf_n;
         if (xfer) begin
            word_valid <= 1'b1;
            word_data  <= dct_buffer;
            word_cnt   <= dct_count;
         end else if (word_ready) begin
            word_valid <= 1'b0;
         end
      end
   end

`ifdef DCT_TIMESTAMP_EN
   logic [15:0] ts_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         ts_cnt  <= '0;
         word_ts <= '0;
      end else begin
         ts_cnt <= ts_cnt + 16'd1;
         if (xfer) word_ts <= ts_cnt;
      end
   end
`else
   assign word_ts = 16'd0;
`endif

endmodule

// File: tb/tb_stopwatch_cpu_oci_dct_ctrl.sv
// Directed bench for stopwatch_cpu_oci_dct_ctrl, built with IDLE_FLUSH=4.
// Hand-computed expectations for fill, flush, idle flush, overflow and reset.
module tb_stopwatch_cpu_oci_dct_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        trc_on = 1'b0;
   logic        frag_valid = 1'b0;
   logic [1:0]  frag = 2'b00;
   logic        flush = 1'b0;
   logic        ovf_clr = 1'b0;
   logic        word_ready = 1'b0;
   logic [29:0] dct_buffer;
   logic [3:0]  dct_count;
   logic        word_valid;
   logic [29:0] word_data;
   logic [3:0]  word_cnt;
   logic        overflow;
   logic [15:0] word_ts;

   int compared = 0;
   int mismatched = 0;

   stopwatch_cpu_oci_dct_ctrl #(.IDLE_FLUSH(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .trc_on     (trc_on),
      .frag_valid (frag_valid),
      .frag       (frag),
      .flush      (flush),
      .ovf_clr    (ovf_clr),
      .dct_buffer (dct_buffer),
      .dct_count  (dct_count),
      .word_valid (word_valid),
      .word_ready (word_ready),
      .word_data  (word_data),
      .word_cnt   (word_cnt),
      .overflow   (overflow),
      .word_ts    (word_ts)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step();
      step();
      compared++;
      if (word_valid !== 1'b0) begin
         mismatched++;
         $display("FAIL reset_word_valid got=%0b exp=0", word_valid);
      end
      compared++;
      if (dct_count !== 4'd0) begin
         mismatched++;
         $display("FAIL reset_dct_count got=%0d exp=0", dct_count);
      end
      compared++;
      if (dct_buffer !== 30'd0) begin
         mismatched++;
         $display("FAIL reset_dct_buffer got=%h exp=0", dct_buffer);
      end
      compared++;
      if (word_data !== 30'd0 || word_cnt !== 4'd0) begin
         mismatched++;
         $display("FAIL reset_word got=%h/%0d exp=0/0", word_data, word_cnt);
      end
      compared++;
      if (overflow !== 1'b0 || word_ts !== 16'd0) begin
         mismatched++;
         $display("FAIL reset_ovf_ts got=%0b/%h exp=0/0", overflow, word_ts);
      end
      reset = 1'b0;
   endtask

   task automatic test_full_word();
      word_ready = 1'b1;
      trc_on = 1'b1;
      frag = 2'b01;
      frag_valid = 1'b1;
      for (int i = 0; i < 15; i++) step();
      frag_valid = 1'b0;
      compared++;
      if (dct_count !== 4'd15 || dct_buffer !== 30'h15555555) begin
         mismatched++;
         $display("FAIL full_buffer got=%0d/%h exp=15/15555555",
                  dct_count, dct_buffer);
      end
      step();
      compared++;
      if (word_valid !== 1'b1 || word_data !== 30'h15555555) begin
         mismatched++;
         $display("FAIL full_word got=%0b/%h exp=1/15555555",
                  word_valid, word_data);
      end
      compared++;
      if (word_cnt !== 4'd15 || dct_count !== 4'd0) begin
         mismatched++;
         $display("FAIL full_counts got=%0d/%0d exp=15/0", word_cnt, dct_count);
      end
      step();
      compared++;
      if (word_valid !== 1'b0) begin
         mismatched++;
         $display("FAIL full_accept got=%0b exp=0", word_valid);
      end
   endtask

   task automatic test_flush();
      logic [1:0] seq [3];
      bit seen;
      seq[0] = 2'b11;
      seq[1] = 2'b10;
      seq[2] = 2'b01;
      word_ready = 1'b1;
      frag_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         frag = seq[i];
         step();
      end
      frag_valid = 1'b0;
      flush = 1'b1;
      step();
      flush = 1'b0;
      step();
      compared++;
      if (word_valid !== 1'b1 || word_data !== 30'h39 || word_cnt !== 4'd3) begin
         mismatched++;
         $display("FAIL flush_word got=%0b/%h/%0d exp=1/39/3",
                  word_valid, word_data, word_cnt);
      end
      step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (word_valid) seen = 1'b1;
      end
      compared++;
      if (seen !== 1'b0) begin
         mismatched++;
         $display("FAIL flush_idle got_word=%0b exp=0", seen);
      end
   endtask

   task automatic test_overflow();
      word_ready = 1'b0;
      frag_valid = 1'b1;
      frag = 2'b10;
      for (int i = 0; i < 30; i++) begin
         if (i >= 15) frag = 2'b01;
         step();
         if (i == 15) begin
            compared++;
            if (dct_count !== 4'd1 || word_cnt !== 4'd15 || overflow !== 1'b0) begin
               mismatched++;
               $display("FAIL boundary got=%0d/%0d/%0b exp=1/15/0",
                        dct_count, word_cnt, overflow);
            end
         end
      end
      frag = 2'b11;
      step();
      frag_valid = 1'b0;
      compared++;
      if (word_valid !== 1'b1 || word_data !== 30'h2AAAAAAA || word_cnt !== 4'd15) begin
         mismatched++;
         $display("FAIL ovf_held got=%0b/%h/%0d exp=1/2aaaaaaa/15",
                  word_valid, word_data, word_cnt);
      end
      compared++;
      if (dct_count !== 4'd15 || dct_buffer !== 30'h15555555 || overflow !== 1'b1) begin
         mismatched++;
         $display("FAIL ovf_drop got=%0d/%h/%0b exp=15/15555555/1",
                  dct_count, dct_buffer, overflow);
      end
      ovf_clr = 1'b1;
      frag_valid = 1'b1;
      step();
      compared++;
      if (overflow !== 1'b1) begin
         mismatched++;
         $display("FAIL ovf_set_clr got=%0b exp=1", overflow);
      end
      frag_valid = 1'b0;
      step();
      ovf_clr = 1'b0;
      compared++;
      if (overflow !== 1'b0) begin
         mismatched++;
         $display("FAIL ovf_clr got=%0b exp=0", overflow);
      end
      word_ready = 1'b1;
      step();
      compared++;
      if (word_valid !== 1'b1 || word_data !== 30'h15555555 || word_cnt !== 4'd15) begin
         mismatched++;
         $display("FAIL back_to_back got=%0b/%h/%0d exp=1/15555555/15",
                  word_valid, word_data, word_cnt);
      end
      step();
      compared++;
      if (word_valid !== 1'b0 || dct_count !== 4'd0) begin
         mismatched++;
         $display("FAIL drain got=%0b/%0d exp=0/0", word_valid, dct_count);
      end
   endtask

   task automatic test_idle_flush();
      int n;
      word_ready = 1'b1;
      frag = 2'b11;
      frag_valid = 1'b1;
      step();
      frag_valid = 1'b0;
      n = 0;
      while (!word_valid && n < 20) begin
         step();
         n++;
      end
      compared++;
      if (n !== 5) begin
         mismatched++;
         $display("FAIL idle_latency got=%0d exp=5", n);
      end
      compared++;
      if (word_valid !== 1'b1 || word_cnt !== 4'd1 || word_data !== 30'h3) begin
         mismatched++;
         $display("FAIL idle_word got=%0b/%0d/%h exp=1/1/3",
                  word_valid, word_cnt, word_data);
      end
      step();
   endtask

   task automatic test_trc_off();
      int n;
      word_ready = 1'b1;
      frag_valid = 1'b1;
      frag = 2'b01;
      step();
      frag = 2'b10;
      step();
      trc_on = 1'b0;
      frag = 2'b11;
      step();
      compared++;
      if (dct_count !== 4'd2 || dct_buffer !== 30'h6) begin
         mismatched++;
         $display("FAIL trc_off_ignore got=%0d/%h exp=2/6", dct_count, dct_buffer);
      end
      n = 0;
      while (!word_valid && n < 20) begin
         step();
         n++;
      end
      compared++;
      if (word_valid !== 1'b1 || word_cnt !== 4'd2 || word_data !== 30'h6) begin
         mismatched++;
         $display("FAIL trc_off_flush got=%0b/%0d/%h exp=1/2/6",
                  word_valid, word_cnt, word_data);
      end
      frag_valid = 1'b0;
      trc_on = 1'b1;
      step();
   endtask

   task automatic test_reset_mid();
      bit seen;
      word_ready = 1'b0;
      frag = 2'b01;
      frag_valid = 1'b1;
      for (int i = 0; i < 22; i++) step();
      frag_valid = 1'b0;
      compared++;
      if (dct_count !== 4'd7 || word_valid !== 1'b1) begin
         mismatched++;
         $display("FAIL mid_setup got=%0d/%0b exp=7/1", dct_count, word_valid);
      end
      reset = 1'b1;
      frag_valid = 1'b1;
      flush = 1'b1;
      word_ready = 1'b1;
      step();
      reset = 1'b0;
      frag_valid = 1'b0;
      flush = 1'b0;
      compared++;
      if (word_valid !== 1'b0 || dct_count !== 4'd0 || dct_buffer !== 30'd0
          || word_data !== 30'd0 || word_cnt !== 4'd0 || overflow !== 1'b0
          || word_ts !== 16'd0) begin
         mismatched++;
         $display("FAIL mid_reset got=%0b/%0d/%h/%h/%0d/%0b/%h exp=all0",
                  word_valid, dct_count, dct_buffer, word_data, word_cnt,
                  overflow, word_ts);
      end
      frag_valid = 1'b1;
      frag = 2'b10;
      seen = 1'b0;
      for (int i = 0; i < 15; i++) begin
         step();
         if (word_valid) seen = 1'b1;
      end
      frag_valid = 1'b0;
      compared++;
      if (seen !== 1'b0) begin
         mismatched++;
         $display("FAIL mid_no_word got_word=%0b exp=0", seen);
      end
      step();
`ifdef DCT_TIMESTAMP_EN
      compared++;
      if (word_valid !== 1'b1 || word_ts !== 16'd15) begin
         mismatched++;
         $display("FAIL ts_value got=%0b/%0d exp=1/15", word_valid, word_ts);
      end
`else
      compared++;
      if (word_valid !== 1'b1 || word_ts !== 16'd0) begin
         mismatched++;
         $display("FAIL ts_tied got=%0b/%0d exp=1/0", word_valid, word_ts);
      end
`endif
      step();
   endtask

   initial begin
      test_reset();
      test_full_word();
      test_flush();
      test_overflow();
      test_idle_flush();
      test_trc_off();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1);
   end

endmodule
